mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single-ported unified memory between the instruction-fetch requester (port 0) and the load/store requester (port 1). Latches the winning request, inserts a parameterised number of wait states, drives one memory access cycle, then returns read data with a one-cycle acknowledge. Sits between the multicycle core's fetch/data interfaces and the memory's memwrite/adr/writedata/memdata pins.

## Interface

- WIDTH, 32, data and address width.
- WAITS, 0, wait-state cycles inserted before each memory access (0..15).
- clk  in  1  clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  access request, port 0 (fetch) / port 1 (data); held high until ack.
- we0 / we1  in  1  write enable for the port's request.
- adr0 / adr1  in  WIDTH  byte address for the port.
- wd0 / wd1  in  WIDTH  write data for the port.
- ack0 / ack1  out  1  one-cycle completion pulse.
- rd0 / rd1  out  WIDTH  read data; valid in the ack cycle, then held until the port's next ack.
- mem_we  out  1  to memory memwrite.
- mem_adr  out  WIDTH  to memory adr.
- mem_wd  out  WIDTH  to memory writedata.
- mem_rd  in  WIDTH  from memory memdata (combinational read).
- busy  out  1  high in every state except IDLE.

## Operation

- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: if any req is high, pick a winner, latch its we/adr/wd and the port ID, and load the wait counter with WAITS. Go to WAIT if WAITS>0, otherwise go to ACCESS. With no request, stay in IDLE.
- WAIT: decrement the counter each cycle. When the counter reads 1, go to ACCESS. Memory outputs stay at their inactive values.
- ACCESS: lasts exactly one cycle. mem_adr and mem_wd carry the latched values; mem_we equals the latched we. At the end of the cycle, capture mem_rd into the winner's rd register (reads only; a write leaves rd unchanged). Go to RESP.
- RESP: lasts exactly one cycle. ackN is high for the latched port only. Requests are ignored. Go to IDLE.
- Requesters must drop req, or present a new request, in the cycle after ack. A req still high at IDLE is treated as a new access.
- Outside ACCESS: mem_we=0, mem_adr=latched adr, mem_wd=latched wd.
- Address and data are latched only in IDLE. Changes on adrN/wdN after grant have no effect.
- Simultaneous req0 and req1 in IDLE: resolved per Configuration. The loser keeps req high and is served in the next IDLE.
- Reset asserted mid-access: the FSM returns to IDLE immediately, no ack is issued, and any pending write is dropped. The requester must re-issue.

## Timing

- Reset values: state=IDLE, ack0=ack1=0, rd0=rd1=0, mem_we=0, mem_adr=0, mem_wd=0, busy=0, counter=0, last-winner=port 1.
- Request sampled at edge T (state IDLE): ACCESS occupies cycle T+WAITS+1, ack is high in cycle T+WAITS+2, and the next IDLE is T+WAITS+3.
- Each access takes WAITS+3 cycles. Throughput is one access per WAITS+3 cycles.
- The write commits at the posedge that ends the ACCESS cycle.
- The ack outputs and the rd registers are registered, not combinational.

## Configuration

- MEM_ARB_RR_EN defined: round-robin arbitration. On a tie, the port that did not win last gets the grant. The last-winner bit updates on every grant.
- MEM_ARB_RR_EN undefined: fixed priority, port 1 (data) always wins ties. The last-winner bit is absent.

## Test plan

- WAITS=0. req0 read at adr 0x10, memory word 4 = 0xDEADBEEF: ACCESS one cycle after the request edge, ack0 pulses one cycle later with rd0=0xDEADBEEF, and ack1 stays 0.
- WAITS=3. req1 write of 0x12345678 to adr 0x20, then req0 read of adr 0x20: mem_we is high for exactly one cycle, 4 cycles after grant. The read returns 0x12345678 and each ack comes WAITS+2=5 cycles after its grant edge.
- req0 and req1 high together and held for 4 accesses: with MEM_ARB_RR_EN the ack order is 0,1,0,1 (reset last-winner=1). Without the macro the order is 1,1,1,1 while req1 stays high.
- Change adr0 from 0x10 to 0x30 in the WAIT state: the access still uses 0x10.
- Deassert reset_n during WAIT of a write to 0x40: the FSM returns to IDLE, there is no ack and no mem_we pulse, and memory word 0x10 is unchanged.
- Idle with no requests for 10 cycles: busy=0, mem_we=0, ack0=ack1=0 throughout.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-ported memory between fetch (port 0) and load/store (port 1).
// Optional feature: define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 1 has fixed priority.
module mem_arbiter #(
    parameter int WIDTH = 32,
    parameter int WAITS = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [WIDTH-1:0] adr0,
    input  logic [WIDTH-1:0] adr1,
    input  logic [WIDTH-1:0] wd0,
    input  logic [WIDTH-1:0] wd1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] rd0,
    output logic [WIDTH-1:0] rd1,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAITS);
    localparam bit         HAS_WAIT  = (WAITS > 0);

    state_t             state;
    state_t             state_nx;
    logic [3:0]         cnt;
    logic               port_q;
    logic               we_q;
    logic [WIDTH-1:0]   adr_q;
    logic [WIDTH-1:0]   wd_q;
    logic               grant;
    logic               grant_port;

    assign grant = (state == IDLE) && (req0 || req1);

`ifdef MEM_ARB_RR_EN
    logic last_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last_q <= 1'b1;
        else if (grant)
            last_q <= grant_port;
    end

    always_comb begin
        grant_port = req1;
        if (req0 && req1)
            grant_port = ~last_q;
    end
`else
    // Fixed priority: req1 wins whenever it is present, so the winner is simply req1.
    always_comb begin
        grant_port = req1;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req0 || req1)
                    state_nx = HAS_WAIT ? WAIT : ACCESS;
            end
            WAIT: begin
                if (cnt == 4'd1)
                    state_nx = ACCESS;
            end
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        mem_we = (state == ACCESS) && we_q;
    end

    assign mem_adr = adr_q;
    assign mem_wd  = wd_q;

    // Request fields are captured only at grant; later changes on the port are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            port_q <= 1'b0;
            we_q   <= 1'b0;
            adr_q  <= '0;
            wd_q   <= '0;
        end else if (grant) begin
            port_q <= grant_port;
            we_q   <= grant_port ? we1  : we0;
            adr_q  <= grant_port ? adr1 : adr0;
            wd_q   <= grant_port ? wd1  : wd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= 4'd0;
        else if (grant)
            cnt <= WAIT_LOAD;
        else if (state == WAIT)
            cnt <= cnt - 4'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
        end else begin
            ack0 <= (state == ACCESS) && !port_q;
            ack1 <= (state == ACCESS) &&  port_q;
        end
    end

    // Read data is captured at the end of ACCESS and held until that port's next read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd0 <= '0;
            rd1 <= '0;
        end else if ((state == ACCESS) && !we_q) begin
            if (port_q)
                rd1 <= mem_rd;
            else
                rd0 <= mem_rd;
        end
    end

endmodule
